vehicle_detector: RTL and testbench

VEHICLE_DETECTOR -- requirements
Module: vehicle_detector

---
 rtl/vehicle_detector_pkg.sv | 32 +++
 rtl/vd_debounce.sv | 103 ++++++++++
 rtl/vehicle_detector.sv | 128 ++++++++++++
 tb/tb_vehicle_detector.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/vehicle_detector_pkg.sv
// Shared traffic encodings: road signal colours, debounce FSM states and
// small helpers. Also used by sig_control.
package vehicle_detector_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } sig_e;

  typedef enum logic [1:0] {
    DB_IDLE    = 2'd0,
    DB_ARM     = 2'd1,
    DB_PRESENT = 2'd2,
    DB_REL     = 2'd3
  } db_state_e;

  // Raw 2-bit signal code to colour; the unused code 3 reads as RED.
  function automatic sig_e decode_sig(input logic [1:0] raw);
    case (raw)
      2'd1:    return YELLOW;
      2'd2:    return GREEN;
      default: return RED;
    endcase
  endfunction

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vd_debounce.sv
// Loop-sensor front end: 2-flop synchronizer followed by a debounce FSM.
// Emits a one-cycle registered arrival pulse when a vehicle is accepted
// and a present level while the debounced sensor is held high.
module vd_debounce
  import vehicle_detector_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic clear,
  input  logic loop_in,
  input  logic hold_idle,
  output logic arrival,
  output logic present
);

  localparam int unsigned DBW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DBW-1:0] LAST = DBW'(DEBOUNCE_CYCLES - 1);

  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  db_state_e      state_q, state_d;
  logic [DBW-1:0] cnt_q, cnt_d;
  logic           arrival_q, arrival_d;

  // Register stage: synchronizer, FSM state, debounce counter, arrival pulse.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (clear) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= DB_IDLE;
      cnt_q     <= '0;
      arrival_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arrival_q <= arrival_d;
    end
  end

  // Next-state logic: only the synchronized sample drives the FSM.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    sync1_d   = loop_in;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    arrival_d = 1'b0;
    if (hold_idle) begin
      state_d = DB_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DB_IDLE: begin
          if (sync2_q) begin
            state_d = DB_ARM;
            cnt_d   = DBW'(1);
          end
        end
        DB_ARM: begin
          if (!sync2_q) begin
            state_d = DB_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == LAST) begin
            state_d   = DB_PRESENT;
            cnt_d     = '0;
            arrival_d = 1'b1;
          end else begin
            cnt_d = cnt_q + DBW'(1);
          end
        end
        DB_PRESENT: begin
          if (!sync2_q) begin
            state_d = DB_REL;
            cnt_d   = DBW'(1);
          end
        end
        DB_REL: begin
          if (sync2_q) begin
            state_d = DB_PRESENT;
            cnt_d   = '0;
          end else if (cnt_q == LAST) begin
            state_d = DB_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + DBW'(1);
          end
        end
        default: begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign arrival = arrival_q;
  assign present = (state_q == DB_PRESENT);

endmodule

// File: rtl/vehicle_detector.sv
// Country-road vehicle detector: counts debounced arrivals, drains one car
// per DRAIN_CYCLES of country GREEN, and drives the X request to sig_control.
// Optional stuck-loop detection is built when VD_STUCK_DET_EN is defined.
module vehicle_detector
  import vehicle_detector_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DRAIN_CYCLES    = 8,
  parameter int unsigned CNT_W           = 4,
  parameter int unsigned STUCK_CYCLES    = 64
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             loop_in,
  input  logic [1:0]       cntry,
  output logic             X,
  output logic [CNT_W-1:0] car_count,
  output logic             overflow,
  output logic             stuck
);

  localparam int unsigned DW = cnt_width(DRAIN_CYCLES);
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic             arrival, present, hold_idle;
  logic             departure, draining;
  sig_e             cntry_sig;
  logic [DW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             x_q, x_d;

  vd_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock    (clock),
    .clear    (clear),
    .loop_in  (loop_in),
    .hold_idle(hold_idle),
    .arrival  (arrival),
    .present  (present)
  );

  // Register stage: drain timer, queue count, overflow flag, X request.
  always_ff @(posedge clock) begin
    if (clear) begin
      timer_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      x_q        <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      x_q        <= x_d;
    end
  end

  // Drain timing and queue bookkeeping; a departure only occurs with cars queued.
  always_comb begin
    cntry_sig  = decode_sig(cntry);
    draining   = (cntry_sig == GREEN) && (count_q != '0);
    departure  = 1'b0;
    timer_d    = '0;
    count_d    = count_q;
    overflow_d = overflow_q;
    x_d        = (count_q != '0);
    if (draining) begin
      if (timer_q == DRAIN_LAST) begin
        departure = 1'b1;
      end else begin
        timer_d = timer_q + DW'(1);
      end
    end
    if (arrival && !departure) begin
      if (count_q == CNT_MAX) overflow_d = 1'b1;
      else                    count_d    = count_q + CNT_W'(1);
    end else if (departure && !arrival) begin
      count_d = count_q - CNT_W'(1);
    end
  end

`ifdef VD_STUCK_DET_EN
  localparam int unsigned SW = $clog2(STUCK_CYCLES + 1);
  localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);

  logic [SW-1:0] stuck_cnt_q, stuck_cnt_d;
  logic          stuck_q, stuck_d;

  // Stuck-loop register stage.
  always_ff @(posedge clock) begin
    if (clear) begin
      stuck_cnt_q <= '0;
      stuck_q     <= 1'b0;
    end else begin
      stuck_cnt_q <= stuck_cnt_d;
      stuck_q     <= stuck_d;
    end
  end

  // Count consecutive PRESENT cycles; latch the fault when the limit is reached.
  always_comb begin
    stuck_d     = stuck_q;
    stuck_cnt_d = '0;
    if (present && !stuck_q) begin
      stuck_cnt_d = stuck_cnt_q + SW'(1);
      if (stuck_cnt_q == STUCK_LAST) stuck_d = 1'b1;
    end
  end

  assign hold_idle = stuck_q;
  assign stuck     = stuck_q;
`else
  // STUCK_CYCLES only matters when the stuck detector is built.
  logic stuck_cfg_unused;
  logic present_unused;
  assign stuck_cfg_unused = (STUCK_CYCLES == 0);
  assign present_unused   = present;
  assign hold_idle        = 1'b0;
  assign stuck            = 1'b0;
`endif

  assign X         = x_q;
  assign car_count = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_vehicle_detector.sv
// Directed self-checking bench for vehicle_detector (default parameters).
// Expectations for the stuck-loop test follow VD_STUCK_DET_EN.
module tb_vehicle_detector;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       loop_in = 1'b0;
  logic [1:0] cntry = 2'd0;
  logic       X;
  logic [3:0] car_count;
  logic       overflow;
  logic       stuck;

  int tests = 0;
  int fails = 0;

  vehicle_detector dut (
    .clock    (clock),
    .clear    (clear),
    .loop_in  (loop_in),
    .cntry    (cntry),
    .X        (X),
    .car_count(car_count),
    .overflow (overflow),
    .stuck    (stuck)
  );

  always #5 clock = ~clock;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    loop_in = 1'b1;
    tick(hi);
    loop_in = 1'b0;
    tick(lo);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held three cycles, then idle inputs.
    tick(3);
    clear = 1'b0;
    tick(1);
    check("reset_x", 32'(X), 0);
    check("reset_count", 32'(car_count), 0);
    check("reset_overflow", 32'(overflow), 0);
    check("reset_stuck", 32'(stuck), 0);

    // Glitches of 2 and 3 cycles are rejected.
    pulse(2, 12);
    check("glitch2_count", 32'(car_count), 0);
    pulse(3, 12);
    check("glitch3_count", 32'(car_count), 0);
    check("glitch3_x", 32'(X), 0);

    // A 4-cycle pulse is accepted; count updates 7 edges after the rise.
    loop_in = 1'b1;
    tick(6);
    check("lat_before", 32'(car_count), 0);
    tick(1);
    check("lat_at", 32'(car_count), 1);
    loop_in = 1'b0;
    tick(12);
    check("lat_x", 32'(X), 1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clear_count", 32'(car_count), 0);
    check("clear_x", 32'(X), 0);

    // Three cars queue under RED, then drain one per 8 GREEN cycles.
    cntry = 2'd0;
    pulse(10, 10);
    pulse(10, 10);
    pulse(10, 10);
    check("three_count", 32'(car_count), 3);
    check("three_x", 32'(X), 1);
    cntry = 2'd2;
    tick(8);
    check("drain_first", 32'(car_count), 2);
    tick(16);
    check("drain_all", 32'(car_count), 0);
    check("drain_x_lag", 32'(X), 1);
    tick(1);
    check("drain_x_off", 32'(X), 0);
    cntry = 2'd0;

    // YELLOW and code 3 never drain.
    pulse(10, 10);
    cntry = 2'd1;
    tick(20);
    check("yellow_hold", 32'(car_count), 1);
    cntry = 2'd3;
    tick(20);
    check("code3_hold", 32'(car_count), 1);
    cntry = 2'd0;

    // Arrival coinciding with a departure at count 2 leaves the count at 2.
    pulse(10, 10);
    check("coinc_pre", 32'(car_count), 2);
    cntry = 2'd2;
    tick(1);
    loop_in = 1'b1;
    tick(6);
    check("coinc_before", 32'(car_count), 2);
    tick(1);
    check("coinc_at", 32'(car_count), 2);
    cntry = 2'd0;
    loop_in = 1'b0;
    tick(12);
    check("coinc_after", 32'(car_count), 2);

    // Clear in the middle of a debounce abandons the arrival.
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    loop_in = 1'b1;
    tick(4);
    clear = 1'b1;
    loop_in = 1'b0;
    tick(1);
    clear = 1'b0;
    tick(12);
    check("clr_mid_db", 32'(car_count), 0);

    // Clear in the middle of a drain empties the queue.
    pulse(10, 10);
    cntry = 2'd2;
    tick(5);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    cntry = 2'd0;
    tick(2);
    check("clr_mid_drain", 32'(car_count), 0);

    // Saturation: 15 cars fit, the 16th and 17th set overflow.
    for (int i = 0; i < 15; i++) pulse(10, 10);
    check("sat15_count", 32'(car_count), 15);
    check("sat15_overflow", 32'(overflow), 0);
    pulse(10, 10);
    pulse(10, 10);
    check("sat17_count", 32'(car_count), 15);
    check("sat17_overflow", 32'(overflow), 1);
    check("sat17_x", 32'(X), 1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("sat_clr_overflow", 32'(overflow), 0);
    check("sat_clr_count", 32'(car_count), 0);

    // Loop held high for 80 cycles.
    loop_in = 1'b1;
    tick(69);
    check("stuck_before", 32'(stuck), 0);
    tick(1);
`ifdef VD_STUCK_DET_EN
    check("stuck_at", 32'(stuck), 1);
`else
    check("stuck_at", 32'(stuck), 0);
`endif
    check("stuck_count", 32'(car_count), 1);
    tick(10);
    loop_in = 1'b0;
    tick(12);
    pulse(10, 12);
`ifdef VD_STUCK_DET_EN
    check("stuck_ignore", 32'(car_count), 1);
    check("stuck_sticky", 32'(stuck), 1);
`else
    check("stuck_ignore", 32'(car_count), 2);
    check("stuck_sticky", 32'(stuck), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
